hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Produces the stall/bubble/flush controls that the EXE-stage forwarding logic relies on.
//  Handles three hazard classes:
//   - load-use hazards, which forwarding cannot resolve;
//   - taken-branch/jump redirects in EXE;
//   - multi-cycle data-memory waits.
//  Sits beside the ID stage; drives the write enables of PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB.
//  Keeps hazard statistics and a sticky memory-timeout error.
// PARAMETERS
//  CNT_W        32  width of statistics counters (saturating)
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before timeout error (>=1)
// PORTS
//  clk                 in   1  clock; all state updates on rising edge
//  rst                 in   1  synchronous, active-high reset
//  IF_ID_read_reg1     in   5  rs1 of instruction in ID
//  IF_ID_read_reg2     in   5  rs2 of instruction in ID
//  IF_ID_use_reg1      in   1  ID instruction actually reads rs1
//  IF_ID_use_reg2      in   1  ID instruction actually reads rs2
//  ID_EXE_mem_r        in   1  instruction in EXE is a load
//  ID_EXE_written_reg  in   5  rd of instruction in EXE
//  EXE_branch_taken    in   1  EXE resolves taken branch/jump (PC redirect this cycle)
//  dmem_req            in   1  EXE_MEM instruction is accessing data memory
//  dmem_ready          in   1  data memory completes the access this cycle
//  PC_write            out  1  PC update enable
//  IF_ID_write         out  1  IF_ID register load enable
//  IF_ID_flush         out  1  clear IF_ID to NOP
//  ID_EXE_flush        out  1  clear ID_EXE to NOP (bubble)
//  pipe_freeze         out  1  hold EXE_MEM and MEM_WB (memory wait)
//  mem_timeout_err     out  1  sticky: a memory wait exceeded MEM_TIMEOUT
//  load_stall_cnt      out  CNT_W  cycles stalled for load-use
//  flush_cnt           out  CNT_W  branch flush events
//  mem_wait_cnt        out  CNT_W  cycles spent frozen for memory
// BEHAVIOUR
//  Reset values (one edge of rst=1):
//   - FSM=RUN; all counters 0; mem_timeout_err=0; internal wait timer 0.
//   - Controls then take their RUN/no-hazard values: PC_write=1, IF_ID_write=1, all flush/freeze=0.
//  Control outputs are combinational from the registered state plus current inputs (zero latency).
//  Hazard detection:
//   - load_use = ID_EXE_mem_r & ID_EXE_written_reg!=0 & ((use1 & rd==rs1) | (use2 & rd==rs2)).
//   - mem_busy = dmem_req & ~dmem_ready.
//  FSM states: RUN, MEM_WAIT.
//  RUN:
//   - If mem_busy: pipe_freeze=1, PC_write=0, IF_ID_write=0, no flush; next=MEM_WAIT; timer<=1.
//   - Else if EXE_branch_taken: IF_ID_flush=1, ID_EXE_flush=1, PC_write=1 (redirect); flush_cnt++.
//   - Else if load_use: PC_write=0, IF_ID_write=0, ID_EXE_flush=1; load_stall_cnt++.
//   - Branch beats load_use: the stalled instruction is squashed anyway.
//  MEM_WAIT:
//   - Same outputs as mem_busy in RUN; mem_wait_cnt++ every cycle in MEM_WAIT.
//   - dmem_ready=1: controls this cycle as in RUN, with mem_busy treated as 0.
//     Branch/load-use is evaluated the same cycle; next=RUN; timer<=0.
//   - Else timer++. When timer==MEM_TIMEOUT: set mem_timeout_err (sticky until rst).
//     Force next=RUN so the core is not deadlocked; the access is treated as completed.
//  Counters saturate at all-ones; no wrap.
//  x0 is never a hazard.
//  rst asserted mid-MEM_WAIT: the next state is RUN, regardless of dmem_ready.
// TESTING
//  1. lw x5 in EXE, ID reads x5 as rs1 -> 1 cycle:
//     PC_write=0, IF_ID_write=0, ID_EXE_flush=1; load_stall_cnt=1.
//  2. lw x0 in EXE, ID rs1=x0 -> no stall; all controls at defaults.
//  3. EXE_branch_taken=1 with load_use=1 in same cycle ->
//     IF_ID_flush=ID_EXE_flush=1, PC_write=1; flush_cnt=1, load_stall_cnt=0.
//  4. dmem_req=1, dmem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles.
//     mem_wait_cnt=2 (MEM_WAIT cycles before ready) +1 on ready cycle = 3; back to RUN.
//  5. MEM_TIMEOUT=4, dmem_ready held 0 ->
//     mem_timeout_err=1 after 4th MEM_WAIT cycle; FSM returns to RUN; err stays 1.
//  6. rst=1 during MEM_WAIT ->
//     next cycle RUN, counters 0, err 0, PC_write=1, pipe_freeze=0.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the pipeline control fabric (master) and hazard_stall_unit (slave).
// dmem_req/dmem_ready form a valid/ready pair: an access is outstanding from the first cycle
// dmem_req is high until the first cycle dmem_ready is high (inclusive); ready may rise with req.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_read_reg1;
  logic [4:0]       IF_ID_read_reg2;
  logic             IF_ID_use_reg1;
  logic             IF_ID_use_reg2;
  logic             ID_EXE_mem_r;
  logic [4:0]       ID_EXE_written_reg;
  logic             EXE_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;

  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EXE_flush;
  logic             pipe_freeze;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] load_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;
  logic             state_dbg;

  modport master (
    output IF_ID_read_reg1, IF_ID_read_reg2, IF_ID_use_reg1, IF_ID_use_reg2,
           ID_EXE_mem_r, ID_EXE_written_reg, EXE_branch_taken, dmem_req, dmem_ready,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, pipe_freeze,
           mem_timeout_err, load_stall_cnt, flush_cnt, mem_wait_cnt, state_dbg
  );

  modport slave (
    input  IF_ID_read_reg1, IF_ID_read_reg2, IF_ID_use_reg1, IF_ID_use_reg2,
           ID_EXE_mem_r, ID_EXE_written_reg, EXE_branch_taken, dmem_req, dmem_ready,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, pipe_freeze,
           mem_timeout_err, load_stall_cnt, flush_cnt, mem_wait_cnt, state_dbg
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/bubble/flush control for load-use, taken-branch and data-memory-wait hazards,
// with saturating hazard statistics and a sticky memory-timeout error.
module hazard_stall_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_unit_if.slave   hz
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic mem_busy;
  logic hold;
  logic inc_stall;
  logic inc_flush;
  logic inc_wait;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = hz.ID_EXE_mem_r && (hz.ID_EXE_written_reg != 5'd0) &&
                    ((hz.IF_ID_use_reg1 && (hz.ID_EXE_written_reg == hz.IF_ID_read_reg1)) ||
                     (hz.IF_ID_use_reg2 && (hz.ID_EXE_written_reg == hz.IF_ID_read_reg2)));

  assign mem_busy = hz.dmem_req && !hz.dmem_ready;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    err_d    = err_q;
    hold     = 1'b0;
    inc_wait = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          timer_d = TW'(1);
        end
      end
      MEM_WAIT: begin
        inc_wait = 1'b1;
        if (hz.dmem_ready) begin
          state_d = RUN;
          timer_d = '0;
        end else begin
          hold = 1'b1;
          // Give up on the access rather than deadlock the core; the error stays latched.
          if (timer_q == TW'(MEM_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  // Priority: memory wait freezes everything, a redirect squashes any load-use victim.
  always_comb begin
    hz.PC_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.IF_ID_flush  = 1'b0;
    hz.ID_EXE_flush = 1'b0;
    hz.pipe_freeze  = 1'b0;
    inc_flush       = 1'b0;
    inc_stall       = 1'b0;
    if (hold) begin
      hz.pipe_freeze = 1'b1;
      hz.PC_write    = 1'b0;
      hz.IF_ID_write = 1'b0;
    end else if (hz.EXE_branch_taken) begin
      hz.IF_ID_flush  = 1'b1;
      hz.ID_EXE_flush = 1'b1;
      inc_flush       = 1'b1;
    end else if (load_use) begin
      hz.PC_write     = 1'b0;
      hz.IF_ID_write  = 1'b0;
      hz.ID_EXE_flush = 1'b1;
      inc_stall       = 1'b1;
    end
  end

  assign stall_cnt_d = sat_inc(stall_cnt_q, inc_stall);
  assign flush_cnt_d = sat_inc(flush_cnt_q, inc_flush);
  assign wait_cnt_d  = sat_inc(wait_cnt_q, inc_wait);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign hz.mem_timeout_err = err_q;
  assign hz.load_stall_cnt  = stall_cnt_q;
  assign hz.flush_cnt       = flush_cnt_q;
  assign hz.mem_wait_cnt    = wait_cnt_q;
  assign hz.state_dbg       = state_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed vector table, multi-cycle sequences
// and randomized traffic against a behavioural model of the hazard rules.
module tb_hazard_stall_unit;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CMAX        = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mem_r;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  // ctl order: {PC_write, IF_ID_write, IF_ID_flush, ID_EXE_flush, pipe_freeze}
  typedef struct {
    in_t        in;
    logic [4:0] ctl;
    int         stall;
    int         flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CNT_W)) hz();

  hazard_stall_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];
  vec_t tbl[$];

  // Behavioural model state
  in_t cur;
  int  m_wait, m_waited, m_err, m_stall, m_flush, m_mwait;

  function automatic in_t mk(int rs1, int rs2, int u1, int u2, int mr, int rd,
                             int br, int req, int rdy);
    in_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.mem_r = 1'(mr); v.rd = 5'(rd); v.br = 1'(br); v.req = 1'(req); v.rdy = 1'(rdy);
    return v;
  endfunction

  function automatic vec_t mkv(in_t v, logic [4:0] c, int s, int f);
    vec_t t;
    t.in = v; t.ctl = c; t.stall = s; t.flush = f;
    return t;
  endfunction

  function automatic logic model_lu();
    return cur.mem_r && (cur.rd != 0) &&
           ((cur.u1 && cur.rd == cur.rs1) || (cur.u2 && cur.rd == cur.rs2));
  endfunction

  function automatic logic model_frozen();
    return (m_wait != 0) ? !cur.rdy : (cur.req && !cur.rdy);
  endfunction

  function automatic logic [4:0] model_ctl();
    if (model_frozen()) return 5'b00001;
    if (cur.br)         return 5'b11110;
    if (model_lu())     return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic logic [4:0] dut_ctl();
    return {hz.PC_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EXE_flush, hz.pipe_freeze};
  endfunction

  task automatic model_edge();
    logic frz, lu;
    if (rst) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0; m_mwait = 0;
      return;
    end
    frz = model_frozen();
    lu  = model_lu();
    if (!frz) begin
      if (cur.br) begin
        if (m_flush < CMAX) m_flush++;
      end else if (lu) begin
        if (m_stall < CMAX) m_stall++;
      end
    end
    if (m_wait != 0) begin
      if (m_mwait < CMAX) m_mwait++;
      if (cur.rdy) m_wait = 0;
      else begin
        m_waited++;
        if (m_waited == MEM_TIMEOUT) begin
          m_err  = 1;
          m_wait = 0;
        end
      end
    end else if (cur.req && !cur.rdy) begin
      m_wait   = 1;
      m_waited = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("ctl", 32'(dut_ctl()), 32'(model_ctl()));
    check("load_stall_cnt", 32'(hz.load_stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
    check("mem_wait_cnt", 32'(hz.mem_wait_cnt), 32'(m_mwait));
    check("mem_timeout_err", 32'(hz.mem_timeout_err), 32'(m_err));
    check("state", 32'(hz.state_dbg), 32'(m_wait));
  endtask

  task automatic apply(input in_t v);
    hz.IF_ID_read_reg1    = v.rs1;
    hz.IF_ID_read_reg2    = v.rs2;
    hz.IF_ID_use_reg1     = v.u1;
    hz.IF_ID_use_reg2     = v.u2;
    hz.ID_EXE_mem_r       = v.mem_r;
    hz.ID_EXE_written_reg = v.rd;
    hz.EXE_branch_taken   = v.br;
    hz.dmem_req           = v.req;
    hz.dmem_ready         = v.rdy;
  endtask

  task automatic drive(input in_t v, input logic r);
    @(negedge clk);
    rst = r;
    cur = v;
    apply(v);
    #1;
    if (!r) check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    tick();
  endtask

  in_t idle, busy, done, nowait, lu_v, br_v, rv;
  int  nf;

  initial begin
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    busy   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    done   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    nowait = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu_v   = mk(5, 0, 1, 0, 1, 5, 0, 0, 1);
    br_v   = mk(0, 0, 0, 0, 0, 0, 1, 0, 1);
    rst = 1'b1;
    cur = idle;
    apply(idle);
    m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0; m_mwait = 0;

    tbl.push_back(mkv(mk(5, 0, 1, 0, 1, 5, 0, 0, 1), 5'b00010, 1, 0)); // load-use rs1
    tbl.push_back(mkv(mk(0, 0, 1, 0, 1, 0, 0, 0, 1), 5'b11000, 0, 0)); // load to x0
    tbl.push_back(mkv(mk(5, 0, 1, 0, 1, 5, 1, 0, 1), 5'b11110, 0, 1)); // branch beats load-use
    tbl.push_back(mkv(mk(3, 7, 1, 1, 1, 7, 0, 0, 1), 5'b00010, 1, 0)); // load-use rs2
    tbl.push_back(mkv(mk(3, 7, 1, 0, 1, 7, 0, 0, 1), 5'b11000, 0, 0)); // rs2 not read
    tbl.push_back(mkv(mk(5, 0, 1, 0, 0, 5, 0, 0, 1), 5'b11000, 0, 0)); // not a load
    tbl.push_back(mkv(mk(5, 0, 1, 0, 1, 5, 1, 1, 0), 5'b00001, 0, 0)); // mem busy beats all
    tbl.push_back(mkv(mk(5, 0, 1, 0, 1, 5, 0, 1, 1), 5'b00010, 1, 0)); // mem ready same cycle
    tbl.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 5'b11110, 0, 1)); // branch only

    // Reset state
    do_reset();
    drive(idle, 1'b0);
    check("reset_ctl", 32'(dut_ctl()), 32'(5'b11000));
    check("reset_err", 32'(hz.mem_timeout_err), 32'd0);
    tick();

    // Vector table
    foreach (tbl[i]) begin
      do_reset();
      exp_q.push_back(tbl[i].ctl);
      drive(tbl[i].in, 1'b0);
      check($sformatf("tbl%0d_ctl", i), 32'(dut_ctl()), 32'(exp_q.pop_front()));
      tick();
      drive(idle, 1'b0);
      check($sformatf("tbl%0d_stall", i), 32'(hz.load_stall_cnt), 32'(tbl[i].stall));
      check($sformatf("tbl%0d_flush", i), 32'(hz.flush_cnt), 32'(tbl[i].flush));
      tick();
    end

    // Memory wait: ready low three cycles, then high
    do_reset();
    nf = 0;
    for (int k = 0; k < 3; k++) begin
      drive(busy, 1'b0);
      nf += int'(hz.pipe_freeze);
      tick();
    end
    drive(done, 1'b0);
    nf += int'(hz.pipe_freeze);
    tick();
    drive(idle, 1'b0);
    check("memwait_freeze_cycles", 32'(nf), 32'd3);
    check("memwait_cnt", 32'(hz.mem_wait_cnt), 32'd3);
    check("memwait_back_to_run", 32'(hz.state_dbg), 32'd0);
    tick();

    // Timeout: ready held low
    do_reset();
    drive(busy, 1'b0);
    tick();
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      drive(busy, 1'b0);
      if (k == MEM_TIMEOUT) check("err_before_timeout", 32'(hz.mem_timeout_err), 32'd0);
      tick();
    end
    drive(nowait, 1'b0);
    check("err_after_timeout", 32'(hz.mem_timeout_err), 32'd1);
    check("run_after_timeout", 32'(hz.state_dbg), 32'd0);
    tick();
    for (int k = 0; k < 3; k++) begin drive(idle, 1'b0); tick(); end
    drive(idle, 1'b0);
    check("err_sticky", 32'(hz.mem_timeout_err), 32'd1);
    tick();

    // Reset asserted mid-wait
    drive(busy, 1'b0); tick();
    drive(busy, 1'b0); tick();
    drive(busy, 1'b1); tick();
    drive(nowait, 1'b0);
    check("rst_state", 32'(hz.state_dbg), 32'd0);
    check("rst_err", 32'(hz.mem_timeout_err), 32'd0);
    check("rst_mwait_cnt", 32'(hz.mem_wait_cnt), 32'd0);
    check("rst_pc_write", 32'(hz.PC_write), 32'd1);
    check("rst_freeze", 32'(hz.pipe_freeze), 32'd0);
    tick();

    // Counter saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin drive(lu_v, 1'b0); tick(); end
    for (int k = 0; k < 20; k++) begin drive(br_v, 1'b0); tick(); end
    for (int k = 0; k < 25; k++) begin drive(busy, 1'b0); tick(); end
    drive(idle, 1'b0);
    check("sat_stall", 32'(hz.load_stall_cnt), 32'(CMAX));
    check("sat_flush", 32'(hz.flush_cnt), 32'(CMAX));
    check("sat_mwait", 32'(hz.mem_wait_cnt), 32'(CMAX));
    tick();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rv = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
              (n < 1500) ? (($urandom_range(0, 3) == 0) ? 1 : 0)
                         : (($urandom_range(0, 3) != 0) ? 1 : 0));
      drive(rv, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
